// File: rtl/alu16_exec_mem_pkg.sv
// Shared encodings for the execute/memory stage: ALUOp, ALUCtrl and opcode values.
package alu16_exec_mem_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  // Bit 3 is Bnegate, bits 2:0 select the result mux leg.
  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_SUB = 4'b1010,
    CTRL_SLT = 4'b1011,
    CTRL_XOR = 4'b0100,
    CTRL_NOR = 4'b0101,
    CTRL_SLL = 4'b0110,
    CTRL_SRL = 4'b0111
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    OPC_R_ARITH = 4'b0000,
    OPC_R_LOGIC = 4'b0001,
    OPC_R_SHIFT = 4'b0010,
    OPC_ADDI    = 4'b0100,
    OPC_SUBI    = 4'b0101,
    OPC_ANDI    = 4'b0110,
    OPC_ORI     = 4'b0111,
    OPC_SLTI    = 4'b1000
  } opcode_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

endpackage

// File: rtl/alu16_data_mem.sv
// Word-organised data memory: async clear on reset, synchronous write, combinational read.
module alu16_data_mem
  import alu16_exec_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [IDX_W-1:0] Index,
  input  logic             RdEn,
  input  logic             WrEn,
  input  logic [15:0]      WrData,
  output logic [15:0]      RdData
);

  logic [15:0] mem [DEPTH_WORDS];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (WrEn) begin
      mem[Index] <= WrData;
    end
  end

  assign RdData = RdEn ? mem[Index] : '0;

endmodule

// File: rtl/alu16_exec_mem.sv
// Execute/memory stage: ALU control decode, 16-bit ALU with flags, and data memory.
module alu16_exec_mem
  import alu16_exec_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [1:0]  ALUOp,
  input  logic [3:0]  Opcode,
  input  logic [1:0]  Funct,
  input  logic [3:0]  Shamt,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] StoreData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [15:0] ALUResult,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [15:0] MemReadData
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  alu_ctrl_e   alu_ctrl;
  logic        b_neg;
  logic [2:0]  op;
  logic [15:0] b_eff;
  logic [16:0] sum;
  logic        add_ovf;

  always_comb begin
    alu_ctrl = CTRL_ADD;
    case (ALUOp)
      ALUOP_ADD: alu_ctrl = CTRL_ADD;
      ALUOP_SUB: alu_ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (Opcode)
          OPC_R_ARITH: begin
            case (Funct)
              2'b00:   alu_ctrl = CTRL_ADD;
              2'b01:   alu_ctrl = CTRL_SUB;
              2'b10:   alu_ctrl = CTRL_SLT;
              default: alu_ctrl = CTRL_SLL;
            endcase
          end
          OPC_R_LOGIC: begin
            case (Funct)
              2'b00:   alu_ctrl = CTRL_AND;
              2'b01:   alu_ctrl = CTRL_OR;
              2'b10:   alu_ctrl = CTRL_XOR;
              default: alu_ctrl = CTRL_NOR;
            endcase
          end
          OPC_R_SHIFT: alu_ctrl = (Funct == 2'b01) ? CTRL_SRL : CTRL_SLL;
          default:     alu_ctrl = CTRL_ADD;
        endcase
      end
      default: begin
        case (Opcode)
          OPC_ADDI: alu_ctrl = CTRL_ADD;
          OPC_SUBI: alu_ctrl = CTRL_SUB;
          OPC_ANDI: alu_ctrl = CTRL_AND;
          OPC_ORI:  alu_ctrl = CTRL_OR;
          OPC_SLTI: alu_ctrl = CTRL_SLT;
          default:  alu_ctrl = CTRL_ADD;
        endcase
      end
    endcase
  end

  assign ALUCtrl = alu_ctrl;
  assign b_neg   = alu_ctrl[3];
  assign op      = alu_ctrl[2:0];

  // Subtraction as A + ~B + 1, so CarryOut=1 means "no borrow".
  assign b_eff   = b_neg ? ~B : B;
  assign sum     = {1'b0, A} + {1'b0, b_eff} + {16'b0, b_neg};
  assign add_ovf = (A[15] == b_eff[15]) && (sum[15] != A[15]);

  always_comb begin
    ALUResult = '0;
    Overflow  = 1'b0;
    CarryOut  = 1'b0;
    case (op)
      OP_AND: ALUResult = A & B;
      OP_OR:  ALUResult = A | B;
      OP_ADD: begin
        ALUResult = sum[15:0];
        Overflow  = add_ovf;
        CarryOut  = sum[16];
      end
      OP_SLT: begin
        ALUResult = {15'b0, sum[15] ^ add_ovf};
        Overflow  = add_ovf;
        CarryOut  = sum[16];
      end
      OP_XOR: ALUResult = A ^ B;
      OP_NOR: ALUResult = ~(A | B);
      OP_SLL: ALUResult = A << Shamt;
      default: ALUResult = A >> Shamt;
    endcase
  end

  assign Zero = (ALUResult == '0);

  alu16_data_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_data_mem (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Index   (ALUResult[IDX_W:1]),
    .RdEn    (MemRead),
    .WrEn    (MemWrite),
    .WrData  (StoreData),
    .RdData  (MemReadData)
  );

endmodule

// File: tb/tb_alu16_exec_mem.sv
// Randomized bench for alu16_exec_mem with an arithmetic reference model and literal pins.
module tb_alu16_exec_mem;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  ALUOp = '0;
  logic [3:0]  Opcode = '0;
  logic [1:0]  Funct = '0;
  logic [3:0]  Shamt = '0;
  logic [15:0] A = '0, B = '0, StoreData = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [3:0]  ALUCtrl;
  logic [15:0] ALUResult, MemReadData;
  logic        Zero, Overflow, CarryOut;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  logic [15:0] m_mem [128];

  alu16_exec_mem #(.DEPTH_WORDS(128)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ALUOp(ALUOp), .Opcode(Opcode),
    .Funct(Funct), .Shamt(Shamt), .A(A), .B(B), .StoreData(StoreData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl),
    .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow),
    .CarryOut(CarryOut), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  task automatic do_cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: instruction-level meaning of each ALUOp/opcode/funct combination.
  function automatic logic [3:0] model_ctrl(input logic [1:0] aop, input logic [3:0] opc,
                                            input logic [1:0] fn);
    logic [3:0] arith [4];
    logic [3:0] logi [4];
    arith = '{4'b0010, 4'b1010, 4'b1011, 4'b0110};
    logi  = '{4'b0000, 4'b0001, 4'b0100, 4'b0101};
    if (aop == 2'd0) return 4'b0010;
    if (aop == 2'd1) return 4'b1010;
    if (aop == 2'd2) begin
      if (opc == 4'd0) return arith[fn];
      if (opc == 4'd1) return logi[fn];
      if (opc == 4'd2) return (fn == 2'd1) ? 4'b0111 : 4'b0110;
      return 4'b0010;
    end
    case (opc)
      4'd5:    return 4'b1010;
      4'd6:    return 4'b0000;
      4'd7:    return 4'b0001;
      4'd8:    return 4'b1011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic void model_alu(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] sh, output logic [15:0] r,
                                    output logic ov, output logic cy);
    int sa, sb, ua, ub, t;
    sa = $signed(a); sb = $signed(b); ua = int'(a); ub = int'(b);
    ov = 1'b0; cy = 1'b0; r = '0;
    case (c)
      4'b0010: begin
        t = ua + ub; r = t[15:0]; cy = (t > 65535);
        ov = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'b1010, 4'b1011: begin
        cy = (ua >= ub);
        ov = (sa - sb > 32767) || (sa - sb < -32768);
        t = ua - ub;
        r = (c == 4'b1010) ? t[15:0] : ((sa < sb) ? 16'd1 : 16'd0);
      end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b0110: r = 16'((ua * (1 << sh)) % 65536);
      default: r = 16'(ua / (1 << sh));
    endcase
  endfunction

  function automatic int model_idx(input logic [15:0] addr);
    return (int'(addr) / 2) % 128;
  endfunction

  initial for (int i = 0; i < 128; i++) m_mem[i] = '0;

  always @(posedge Clock or negedge Reset_n) begin
    logic [15:0] r; logic ov, cy;
    if (!Reset_n) begin
      for (int i = 0; i < 128; i++) m_mem[i] = '0;
    end else if (MemWrite) begin
      model_alu(model_ctrl(ALUOp, Opcode, Funct), A, B, Shamt, r, ov, cy);
      m_mem[model_idx(r)] = StoreData;
    end
  end

  always @(negedge Clock) begin
    logic [3:0] c; logic [15:0] r; logic ov, cy;
    if (cmp_on) begin
      c = model_ctrl(ALUOp, Opcode, Funct);
      model_alu(c, A, B, Shamt, r, ov, cy);
      do_cmp("ALUCtrl", 16'(ALUCtrl), 16'(c));
      do_cmp("ALUResult", ALUResult, r);
      do_cmp("Zero", 16'(Zero), 16'(r == 16'h0));
      do_cmp("Overflow", 16'(Overflow), 16'(ov));
      do_cmp("CarryOut", 16'(CarryOut), 16'(cy));
      do_cmp("MemReadData", MemReadData, MemRead ? m_mem[model_idx(r)] : 16'h0);
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic set_op(input logic [1:0] aop, input logic [3:0] opc, input logic [1:0] fn,
                        input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    ALUOp = aop; Opcode = opc; Funct = fn; A = a; B = b; Shamt = sh;
    #1;
  endtask

  task automatic alu_lit(input string name, input logic [15:0] r, input logic ov, input logic cy,
                         input logic z);
    do_cmp({name, ".res"}, ALUResult, r);
    do_cmp({name, ".ovf"}, 16'(Overflow), 16'(ov));
    do_cmp({name, ".cy"}, 16'(CarryOut), 16'(cy));
    do_cmp({name, ".zero"}, 16'(Zero), 16'(z));
  endtask

  logic [15:0] corner [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE};

  initial begin
    step(); step();
    do_cmp("reset.MemReadData", MemReadData, 16'h0);
    Reset_n = 1'b1;
    step();
    cmp_on = 1'b1;

    // Decoder pins
    set_op(2'b10, 4'b0001, 2'b11, 16'h0, 16'h0, 4'd0); do_cmp("dec.NOR", 16'(ALUCtrl), 16'h5);
    set_op(2'b11, 4'b1000, 2'b00, 16'h0, 16'h0, 4'd0); do_cmp("dec.SLTI", 16'(ALUCtrl), 16'hB);
    set_op(2'b01, 4'b0000, 2'b00, 16'h0, 16'h0, 4'd0); do_cmp("dec.SUB", 16'(ALUCtrl), 16'hA);
    set_op(2'b10, 4'b0010, 2'b01, 16'h0, 16'h0, 4'd0); do_cmp("dec.SRL", 16'(ALUCtrl), 16'h7);

    // Arithmetic and logic pins
    set_op(2'b00, 4'h0, 2'b00, 16'h7FFF, 16'h0001, 4'd0); alu_lit("add_ovf", 16'h8000, 1, 0, 0);
    set_op(2'b00, 4'h0, 2'b00, 16'hFFFF, 16'h0001, 4'd0); alu_lit("add_cy", 16'h0000, 0, 1, 1);
    set_op(2'b01, 4'h0, 2'b00, 16'h0005, 16'h0005, 4'd0); alu_lit("sub_eq", 16'h0000, 0, 1, 1);
    set_op(2'b11, 4'h8, 2'b00, 16'hFFFE, 16'h0003, 4'd0); do_cmp("slt1", ALUResult, 16'h1);
    set_op(2'b11, 4'h8, 2'b00, 16'h0003, 16'hFFFE, 4'd0); do_cmp("slt2", ALUResult, 16'h0);
    set_op(2'b11, 4'h8, 2'b00, 16'h8000, 16'h7FFF, 4'd0); do_cmp("slt3", ALUResult, 16'h1);
    set_op(2'b10, 4'h1, 2'b00, 16'hF0F0, 16'h0FF0, 4'd0); alu_lit("and", 16'h00F0, 0, 0, 0);
    set_op(2'b10, 4'h1, 2'b11, 16'h0000, 16'h0000, 4'd0); alu_lit("nor", 16'hFFFF, 0, 0, 0);
    set_op(2'b10, 4'h2, 2'b00, 16'h0001, 16'h0000, 4'd15); alu_lit("sll", 16'h8000, 0, 0, 0);
    set_op(2'b10, 4'h2, 2'b01, 16'h8000, 16'h0000, 4'd4); alu_lit("srl", 16'h0800, 0, 0, 0);

    // Memory: store 1234 at byte address 0x0010
    step();
    set_op(2'b00, 4'h0, 2'b00, 16'h0010, 16'h0000, 4'd0);
    StoreData = 16'h1234; MemWrite = 1'b1; MemRead = 1'b1;
    do_cmp("mem.before_edge", MemReadData, 16'h0000);
    step();
    MemWrite = 1'b0;
    do_cmp("mem.0010", MemReadData, 16'h1234);
    A = 16'h0011; #1; do_cmp("mem.0011", MemReadData, 16'h1234);
    A = 16'h0110; #1; do_cmp("mem.wrap0110", MemReadData, 16'h1234);
    MemRead = 1'b0; #1; do_cmp("mem.rd_off", MemReadData, 16'h0000);

    // Reset clears immediately and blocks writes
    step();
    A = 16'h0004; StoreData = 16'hABCD; MemWrite = 1'b1; MemRead = 1'b1;
    step();
    MemWrite = 1'b0; #1;
    do_cmp("rst.pre", MemReadData, 16'hABCD);
    Reset_n = 1'b0; #1;
    do_cmp("rst.async_clear", MemReadData, 16'h0000);
    StoreData = 16'h5555; MemWrite = 1'b1;
    step();
    do_cmp("rst.write_blocked", MemReadData, 16'h0000);
    Reset_n = 1'b1; #1;
    do_cmp("rst.release_no_write", MemReadData, 16'h0000);
    step();
    do_cmp("rst.first_write", MemReadData, 16'h5555);
    MemWrite = 1'b0;

    // Randomized phase, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 2) == 0) begin
        ALUOp = 2'b00; A = 16'($urandom_range(0, 511)); B = 16'h0;
      end else begin
        ALUOp = 2'($urandom); Opcode = 4'($urandom); Funct = 2'($urandom);
        Shamt = 4'($urandom);
        A = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
        B = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      end
      StoreData = 16'($urandom);
      MemRead = 1'($urandom);
      MemWrite = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
      end
    end

    step();
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu16_exec_mem.md
Name: alu16_exec_mem

Overview:
Execute/memory stage of the 16-bit single-cycle CPU datapath. It has three parts:
- an ALU control decoder that maps ALUOp, opcode and funct to a 4-bit ALUCtrl;
- a 16-bit ALU with zero, overflow and carry flags;
- a word-organised data memory addressed by the ALU result.

It sits between the register file / ALUSrc mux and the MemToReg writeback mux.

Parameters:
DEPTH_WORDS, 128, number of 16-bit data-memory words (power of 2); byte address bits above the index wrap.

Ports:
Clock  in  1  rising-edge clock for memory writes
Reset_n  in  1  asynchronous active-low reset; clears data memory
ALUOp  in  2  from CU: 00 add, 01 sub, 10 R-type (funct), 11 I-type (opcode)
Opcode  in  4  instruction[15:12]
Funct  in  2  instruction[1:0]
Shamt  in  4  instruction[5:2], shift amount
A  in  16  readData1
B  in  16  ALUSrc-muxed operand (readData2 or sign-extended imm8)
StoreData  in  16  readData2, data for stores
MemRead  in  1  read enable
MemWrite  in  1  write enable
ALUCtrl  out  4  decoded control, [3]=Bnegate, [2:0]=op
ALUResult  out  16  ALU result, also the data-memory byte address
Zero  out  1  ALUResult == 0
Overflow  out  1  signed overflow of the adder path
CarryOut  out  1  carry out of the adder path
MemReadData  out  16  memory read data

Behaviour:
ALUCtrl codes:
- AND 0000, OR 0001, ADD 0010, SUB 1010, SLT 1011, XOR 0100, NOR 0101, SLL 0110, SRL 0111.

Decoder (combinational):
- ALUOp 00 -> ADD; ALUOp 01 -> SUB.
- ALUOp 10, Opcode 0000: Funct 00 ADD, 01 SUB, 10 SLT, 11 SLL.
- ALUOp 10, Opcode 0001: Funct 00 AND, 01 OR, 10 XOR, 11 NOR.
- ALUOp 10, Opcode 0010: Funct 01 SRL, else SLL.
- ALUOp 10, any other opcode -> ADD.
- ALUOp 11: Opcode 0100 ADD, 0101 SUB, 0110 AND, 0111 OR, 1000 SLT, else ADD.

ALU (purely combinational, zero latency):
- Adder path: S = A + (Bnegate ? ~B : B) + Bnegate, computed 17 bits wide; CarryOut = bit 16.
- Overflow = (A[15] == B'[15]) && (S[15] != A[15]), where B' is the possibly inverted B.
- SLT result = {15'b0, S[15]^Overflow} (signed compare).
- CarryOut and Overflow are driven for op 010/011 only; they are 0 for all other ops.
- Logic ops: bitwise on A,B; Bnegate is ignored for these ops.
- Shifts operate on A by Shamt (0..15), logical, zero-fill.
- Zero is computed on the final ALUResult.
- Boundaries: 0x7FFF+1 -> 0x8000, Overflow=1, CarryOut=0. 0xFFFF+1 -> 0x0000, Zero=1, CarryOut=1. SUB x-x -> Zero=1, CarryOut=1.

Data memory:
- Array of DEPTH_WORDS 16-bit words.
- Index = ALUResult[log2(DEPTH_WORDS):1]; ALUResult[0] ignored (addresses are byte addresses, words aligned); upper bits wrap.
- Write: synchronous, on posedge Clock when MemWrite=1 and Reset_n=1.
- Read: combinational. MemReadData = mem[index] when MemRead=1, else 16'h0000.
- Same-cycle read and write to the same index: read shows old data until the edge, new data after.
- MemRead=MemWrite=1: both actions occur as described.
- Reset_n=0: all words clear to 0 immediately, independent of Clock; writes are blocked while reset is asserted. Deassertion mid-operation: the first write happens at the next rising edge.
- Reset values: MemReadData=0. The other outputs are combinational functions of the inputs and are not affected by reset.

Decomposition:
- Shared package: ALUOp constants, ALUCtrl code constants, opcode constants (R_ARITH 0000, R_LOGIC 0001, R_SHIFT 0010, ADDI 0100, SUBI 0101, ANDI 0110, ORI 0111, SLTI 1000).
- Decoder and ALU inline in the block.
- One sub-module: alu16_data_mem (memory array, reset clear, sync write, comb read).

Test Plan:
- Decode sweep: ALUOp=10, Opcode=0001, Funct=11 -> ALUCtrl=0101. ALUOp=11, Opcode=1000 -> 1011. ALUOp=01 -> 1010.
- Arithmetic flags:
  - ADD A=7FFF, B=0001 -> 8000, Overflow=1, CarryOut=0, Zero=0.
  - ADD FFFF+0001 -> 0000, Zero=1, CarryOut=1.
  - SUB 0005-0005 -> 0000, Zero=1.
- SLT signed: A=FFFE (-2), B=0003 -> 0001. A=0003, B=FFFE -> 0000. A=8000, B=7FFF -> 0001.
- Logic/shift: AND F0F0&0FF0 -> 00F0; NOR 0000,0000 -> FFFF; SLL A=0001, Shamt=15 -> 8000; SRL A=8000, Shamt=4 -> 0800. Overflow and CarryOut = 0 for all.
- Memory: store 1234 at addr 0x0010 (MemWrite pulse) -> MemRead at 0x0010 and 0x0011 both return 1234. MemRead=0 -> 0000. Addr 0x0110 with DEPTH_WORDS=128 wraps to same word -> 1234.
- Reset: write ABCD at 0x0004, assert Reset_n=0 between clock edges -> MemReadData=0000 immediately; MemWrite held during reset leaves memory 0000; after release, write lands on the next edge.
